// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC, PRId, exception/ERET capture.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise addresses 9/11 read 0.
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif

module cp0_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int INT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cp0_reg_rw,
  input  logic [4:0]            cp0_reg_read_addr,
  output logic [DATA_WIDTH-1:0] cp0_reg_read,
  input  logic [4:0]            cp0_reg_write_addr,
  input  logic [DATA_WIDTH-1:0] cp0_reg_write,
  input  logic [INT_WIDTH-1:0]  int_i,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [DATA_WIDTH-1:0] exc_epc,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic [DATA_WIDTH-1:0] status_o,
  output logic [DATA_WIDTH-1:0] cause_o,
  output logic [DATA_WIDTH-1:0] epc_o,
  output logic                  timer_int,
  output logic                  int_pending
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;
  localparam logic [DATA_WIDTH-1:0] PRID_VAL = 32'h0001_8000;
`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic [7:0]            status_im;
  logic                  status_exl;
  logic                  status_ie;
  logic                  cause_bd;
  logic [1:0]            cause_ip_sw;
  logic [4:0]            cause_exc;
  logic [DATA_WIDTH-1:0] epc;
  logic [DATA_WIDTH-1:0] count_rd;
  logic [DATA_WIDTH-1:0] compare_rd;
  logic [5:0]            ip_hw;
  logic [DATA_WIDTH-1:0] status_val;
  logic [DATA_WIDTH-1:0] cause_val;
  logic                  wr;

  // exception and ERET both suppress an MTC0 in the same cycle
  assign wr = (cp0_reg_rw == `MEM_WRITE) && !exc_valid && !eret;

  assign ip_hw      = {int_i[5] | timer_int, int_i[4:0]};
  assign status_val = {3'b000, 1'b1, 12'h000, status_im, 6'b000000, status_exl, status_ie};
  assign cause_val  = {cause_bd, 15'h0000, ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};

  assign status_o = status_val;
  assign cause_o  = cause_val;
  assign epc_o    = epc;

  assign int_pending = status_ie && !status_exl && |(status_im & cause_val[15:8]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      epc         <= '0;
    end else if (exc_valid) begin
      cause_exc  <= exc_code;
      status_exl <= 1'b1;
      // nested exception keeps the original return point
      if (!status_exl) begin
        epc      <= exc_epc;
        cause_bd <= exc_bd;
      end
    end else if (eret) begin
      status_exl <= 1'b0;
    end else if (wr) begin
      case (cp0_reg_write_addr)
        A_STATUS: begin
          status_im  <= cp0_reg_write[15:8];
          status_exl <= cp0_reg_write[1];
          status_ie  <= cp0_reg_write[0];
        end
        A_CAUSE: cause_ip_sw <= cp0_reg_write[9:8];
        A_EPC:   epc         <= cp0_reg_write;
        default: ;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] compare;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      if (wr && cp0_reg_write_addr == A_COUNT) count <= cp0_reg_write;
      else                                     count <= count + DATA_WIDTH'(1);
      if (wr && cp0_reg_write_addr == A_COMPARE) begin
        compare   <= cp0_reg_write;
        timer_int <= 1'b0;
      end else if (count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end

  assign count_rd   = count;
  assign compare_rd = compare;
`else
  assign timer_int  = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  always_comb begin
    cp0_reg_read = '0;
    if (wr && cp0_reg_write_addr == cp0_reg_read_addr) begin
      case (cp0_reg_read_addr)
        A_COUNT, A_COMPARE: cp0_reg_read = TIMER_EN ? cp0_reg_write : '0;
        A_STATUS: cp0_reg_read = (cp0_reg_write & 32'h0000_FF03) | 32'h1000_0000;
        A_CAUSE:  cp0_reg_read = {cause_val[31:10], cp0_reg_write[9:8], cause_val[7:0]};
        A_EPC:    cp0_reg_read = cp0_reg_write;
        A_PRID:   cp0_reg_read = PRID_VAL;
        default:  cp0_reg_read = '0;
      endcase
    end else begin
      case (cp0_reg_read_addr)
        A_COUNT:   cp0_reg_read = count_rd;
        A_COMPARE: cp0_reg_read = compare_rd;
        A_STATUS:  cp0_reg_read = status_val;
        A_CAUSE:   cp0_reg_read = cause_val;
        A_EPC:     cp0_reg_read = epc;
        A_PRID:    cp0_reg_read = PRID_VAL;
        default:   cp0_reg_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed test-plan steps followed by random traffic against a reference model.
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif

module tb_cp0_regfile;
`ifdef CP0_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cp0_reg_rw;
  logic [4:0]  cp0_reg_read_addr;
  logic [31:0] cp0_reg_read;
  logic [4:0]  cp0_reg_write_addr;
  logic [31:0] cp0_reg_write;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] status_o, cause_o, epc_o;
  logic        timer_int, int_pending;

  int total = 0;
  int bad = 0;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .cp0_reg_rw(cp0_reg_rw),
    .cp0_reg_read_addr(cp0_reg_read_addr), .cp0_reg_read(cp0_reg_read),
    .cp0_reg_write_addr(cp0_reg_write_addr), .cp0_reg_write(cp0_reg_write),
    .int_i(int_i), .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .eret(eret), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .timer_int(timer_int), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  // reference state, kept as architectural fields
  logic [31:0] m_count, m_compare, m_epc;
  logic [7:0]  m_im;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  bit          m_timer, m_exl, m_ie, m_bd;

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_epc = 0; m_im = 0; m_ipsw = 0; m_exc = 0;
    m_timer = 0; m_exl = 0; m_ie = 0; m_bd = 0;
  endtask

  function automatic logic [31:0] exp_status();
    return 32'h1000_0000 | ({24'h0, m_im} << 8) | {30'h0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] exp_cause();
    logic [5:0] hw;
    hw = {int_i[5] | (TEN & m_timer), int_i[4:0]};
    return ({31'h0, m_bd} << 31) | ({26'h0, hw} << 10) | ({30'h0, m_ipsw} << 8) | ({27'h0, m_exc} << 2);
  endfunction

  function automatic bit exp_pend();
    logic [31:0] s, c;
    s = exp_status();
    c = exp_cause();
    return m_ie && !m_exl && ((s[15:8] & c[15:8]) != 8'h00);
  endfunction

  function automatic logic [31:0] exp_read(output bit skip);
    logic [31:0] w;
    w = cp0_reg_write;
    skip = 1'b0;
    if (cp0_reg_rw == `MEM_WRITE && !exc_valid && !eret && cp0_reg_write_addr == cp0_reg_read_addr) begin
      case (cp0_reg_read_addr)
        5'd9, 5'd11: return TEN ? w : 32'h0;
        5'd12: return (w & 32'h0000_FF03) | 32'h1000_0000;
        5'd13: begin skip = 1'b1; return 32'h0; end
        5'd14: return w;
        5'd15: return 32'h0001_8000;
        default: return 32'h0;
      endcase
    end
    case (cp0_reg_read_addr)
      5'd9:  return TEN ? m_count : 32'h0;
      5'd11: return TEN ? m_compare : 32'h0;
      5'd12: return exp_status();
      5'd13: return exp_cause();
      5'd14: return m_epc;
      5'd15: return 32'h0001_8000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit wr, match;
    wr = (cp0_reg_rw == `MEM_WRITE) && !exc_valid && !eret;
    match = TEN && (m_count == m_compare);
    if (exc_valid) begin
      m_exc = exc_code;
      if (!m_exl) begin m_epc = exc_epc; m_bd = exc_bd; end
      m_exl = 1;
    end else if (eret) begin
      m_exl = 0;
    end else if (wr) begin
      if (cp0_reg_write_addr == 5'd12) begin
        m_im = cp0_reg_write[15:8]; m_exl = cp0_reg_write[1]; m_ie = cp0_reg_write[0];
      end
      if (cp0_reg_write_addr == 5'd13) m_ipsw = cp0_reg_write[9:8];
      if (cp0_reg_write_addr == 5'd14) m_epc = cp0_reg_write;
    end
    if (TEN) begin
      if (wr && cp0_reg_write_addr == 5'd9) m_count = cp0_reg_write;
      else m_count = m_count + 1;
      if (wr && cp0_reg_write_addr == 5'd11) begin
        m_compare = cp0_reg_write; m_timer = 0;
      end else if (match) m_timer = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle(input logic [4:0] raddr);
    cp0_reg_rw = `MEM_READ; cp0_reg_write_addr = 0; cp0_reg_write = 0;
    cp0_reg_read_addr = raddr; exc_valid = 0; exc_code = 0; exc_epc = 0; exc_bd = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] waddr, input logic [31:0] w, input logic [4:0] raddr);
    idle(raddr);
    cp0_reg_rw = `MEM_WRITE; cp0_reg_write_addr = waddr; cp0_reg_write = w;
  endtask

  // check combinational outputs, take one edge, check registered outputs
  task automatic cycle();
    bit skip;
    logic [31:0] er;
    #1;
    er = exp_read(skip);
    if (!skip) chk("read", cp0_reg_read, er);
    chk("int_pending", {31'h0, int_pending}, {31'h0, exp_pend()});
    @(posedge clk);
    model_edge();
    #1;
    chk("status_o", status_o, exp_status());
    chk("cause_o", cause_o, exp_cause());
    chk("epc_o", epc_o, m_epc);
    chk("timer_int", {31'h0, timer_int}, {31'h0, TEN & m_timer});
  endtask

  logic [4:0] addrs [7];

  initial begin
    rst = 1; int_i = 0;
    idle(5'd12);
    model_reset();
    #1;
    chk("reset_rd12", cp0_reg_read, 32'h1000_0000);
    cp0_reg_read_addr = 5'd15; #1;
    chk("reset_rd15", cp0_reg_read, 32'h0001_8000);
    cp0_reg_read_addr = 5'd13; #1;
    chk("reset_rd13", cp0_reg_read, 32'h0);
    chk("reset_timer", {31'h0, timer_int}, 32'h0);
    rst = 0;
    cycle();

    mtc0(5'd12, 32'hFFFF_FFFF, 5'd12); #1;
    chk("bypass_status", cp0_reg_read, 32'h1000_FF03);
    cycle();
    chk("status_after_wr", status_o, 32'h1000_FF03);

    mtc0(5'd9, 32'h0, 5'd9); cycle();
    mtc0(5'd11, 32'd3, 5'd11); cycle();
    idle(5'd9); cycle(); cycle();
`ifdef CP0_TIMER_EN
    chk("timer_not_yet", {31'h0, timer_int}, 32'h0);
`endif
    cycle();
`ifdef CP0_TIMER_EN
    chk("timer_rise", {31'h0, timer_int}, 32'h1);
`endif

    int_i = TEN ? 6'h00 : 6'h20;
    mtc0(5'd12, 32'h0000_8001, 5'd12); cycle();
    idle(5'd13); #1;
    chk("pend_on", {31'h0, int_pending}, 32'h1);
    exc_valid = 1; exc_code = 5'd0; exc_epc = 32'h40; exc_bd = 1; cycle();
    idle(5'd14); #1;
    chk("pend_exl", {31'h0, int_pending}, 32'h0);
    chk("epc_exc1", epc_o, 32'h40);
    chk("cause_exc1", cause_o, 32'h8000_8000);
    exc_valid = 1; exc_code = 5'd5; exc_epc = 32'h80; exc_bd = 0; cycle();
    chk("epc_nested", epc_o, 32'h40);
    chk("cause_nested", cause_o, 32'h8000_8014);
    idle(5'd12); eret = 1; cycle();
    chk("status_eret", status_o, 32'h1000_8001);
    mtc0(5'd11, 32'd100, 5'd11); cycle();
    chk("timer_clear", {31'h0, timer_int}, 32'h0);

    mtc0(5'd14, 32'h1234, 5'd14);
    exc_valid = 1; exc_code = 5'd4; exc_epc = 32'h200; exc_bd = 0; #1;
    chk("no_bypass_exc", cp0_reg_read, 32'h40);
    cycle();
    chk("epc_exc_wins", epc_o, 32'h200);

    idle(5'd12); eret = 1; cycle();
    idle(5'd9); cycle(); cycle();
    rst = 1; #1;
    chk("arst_status", status_o, 32'h1000_0000);
    chk("arst_epc", epc_o, 32'h0);
    chk("arst_timer", {31'h0, timer_int}, 32'h0);
    model_reset();
    rst = 0;
    cycle();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      addrs[0] = 5'd9; addrs[1] = 5'd11; addrs[2] = 5'd12; addrs[3] = 5'd13;
      addrs[4] = 5'd14; addrs[5] = 5'd15; addrs[6] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
      w = $urandom;
      idle(addrs[$urandom_range(0, 6)]);
      if ($urandom_range(0, 1) == 1) begin
        cp0_reg_rw = `MEM_WRITE;
        cp0_reg_write_addr = ($urandom_range(0, 2) == 0) ? cp0_reg_read_addr : addrs[$urandom_range(0, 6)];
        if (cp0_reg_write_addr == 5'd11 && $urandom_range(0, 1) == 1) w = m_count + 32'($urandom_range(1, 6));
        if (cp0_reg_write_addr == 5'd9 && $urandom_range(0, 3) == 0) w = 32'hFFFF_FFFD;
        cp0_reg_write = w;
      end
      if ($urandom_range(0, 15) == 0) begin
        exc_valid = 1; exc_code = 5'($urandom); exc_epc = $urandom; exc_bd = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) eret = 1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
